// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline constants: load/store funct3 codes, memory-stage
// state encoding and the bubble values used by the EX/MEM and ID/EX queues.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // {EN, Read}: a bubble is a non-enabled read
    localparam logic [1:0] DATA_CTRL_NOP = 2'b01;
    // {source[1:0], write_reg}: no register write
    localparam logic [2:0] RF_NOP        = 3'b000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    // Access width comes from the low two funct3 bits; bit 2 only selects zero-extension
    function automatic mem_size_e f3_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (f3_size(funct3))
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32_lsu_align.sv
// Combinational lane logic for the data-memory port: replicates store data
// across byte lanes with matching byte enables, and picks/extends load lanes.
module rv32_lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = load_word[8*gi +: 8];
        end
    endgenerate

    // Halves only reach memory when 2-byte aligned, so offset bit 1 picks the pair
    assign byte_sel = lane[byte_off];
    assign half_sel = {lane[{byte_off[1], 1'b1}], lane[{byte_off[1], 1'b0}]};

    // Lane replication, byte-enable shift and load extension per access size
    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = load_word;
        case (f3_size(funct3))
            SIZE_B: begin
                wdata     = {4{store_data[7:0]}};
                be        = 4'b0001 << byte_off;
                load_data = funct3[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                wdata     = {2{store_data[15:0]}};
                be        = 4'b0011 << byte_off;
                load_data = funct3[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32_ex_mem_queue.sv
// EX/MEM pipeline register. Captures EX results while idle, runs the
// data-memory req/ack handshake for loads and stores with a timeout, and
// stalls upstream (busy) until the access retires.
module rv32_ex_mem_queue
    import rv32_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rf_rs2_in,
    input  logic [4:0]  sel_rd1_in,
    input  logic [2:0]  rf_in,
    input  logic [1:0]  data_ctrl_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] code_out,
    output logic [31:0] pc_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] load_data_out,
    output logic [4:0]  sel_rd1_out,
    output logic [2:0]  rf_out,
    output logic        busy,
    output logic        mem_err
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    mem_state_e       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             mem_err_reg;
    logic             suppress_reg;

    logic [31:0] code_reg;
    logic [31:0] pc_reg;
    logic [31:0] alu_reg;
    logic [31:0] rs2_reg;
    logic [4:0]  rd_reg;
    logic [2:0]  rf_reg;
    logic        read_reg;
    logic [31:0] load_data_reg;

    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic [31:0] align_load;

    rv32_lsu_align u_align (
        .funct3     (code_reg[14:12]),
        .byte_off   (alu_reg[1:0]),
        .store_data (rs2_reg),
        .load_word  (dmem_rdata),
        .wdata      (align_wdata),
        .be         (align_be),
        .load_data  (align_load)
    );

    // Handshake outputs derive from state so an async reset drops them at once
    assign busy       = (state_reg == ACCESS);
    assign dmem_req   = busy;
    assign dmem_we    = busy & ~read_reg;
    assign dmem_be    = busy ? align_be : 4'b0000;
    assign dmem_addr  = {alu_reg[31:2], 2'b00};
    assign dmem_wdata = align_wdata;
    assign mem_err    = mem_err_reg;

    assign code_out       = code_reg;
    assign pc_out         = pc_reg;
    assign alu_result_out = alu_reg;
    assign load_data_out  = load_data_reg;
    assign sel_rd1_out    = rd_reg;
    // Writeback sees no register write while waiting or for a faulted access
    assign rf_out         = {rf_reg[2:1], rf_reg[0] & ~busy & ~suppress_reg};

    // Access FSM with wait counter, fault pulse and write-suppress flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            mem_err_reg  <= 1'b0;
            suppress_reg <= 1'b0;
        end else begin
            mem_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg      <= '0;
                    suppress_reg <= 1'b0;
                    if (data_ctrl_in[1]) begin
                        if (is_misaligned(code_in[14:12], alu_result_in[1:0])) begin
                            mem_err_reg  <= 1'b1;
                            suppress_reg <= 1'b1;
                        end else begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // An ack in the final wait cycle still completes the access
                    if (dmem_ack) begin
                        state_reg <= IDLE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg    <= IDLE;
                        mem_err_reg  <= 1'b1;
                        suppress_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Pipeline fields captured on every idle edge; load data on a read ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_reg      <= '0;
            pc_reg        <= '0;
            alu_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            rf_reg        <= RF_NOP;
            read_reg      <= DATA_CTRL_NOP[0];
            load_data_reg <= '0;
        end else begin
            if (state_reg == IDLE) begin
                code_reg <= code_in;
                pc_reg   <= pc_in;
                alu_reg  <= alu_result_in;
                rs2_reg  <= rf_rs2_in;
                rd_reg   <= sel_rd1_in;
                rf_reg   <= rf_in;
                read_reg <= data_ctrl_in[0];
            end
            if (state_reg == ACCESS && dmem_ack && read_reg) begin
                load_data_reg <= align_load;
            end
        end
    end

endmodule

// File: tb/tb_rv32_ex_mem_queue.sv
// Bench for rv32_ex_mem_queue: directed cases followed by random
// transactions, each compared against a transaction-level reference model.
module tb_rv32_ex_mem_queue;
    import rv32_pkg::*;

    localparam int ACK_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] code_in, pc_in, alu_result_in, rf_rs2_in;
    logic [4:0]  sel_rd1_in;
    logic [2:0]  rf_in;
    logic [1:0]  data_ctrl_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] code_out, pc_out, alu_result_out, load_data_out;
    logic [4:0]  sel_rd1_out;
    logic [2:0]  rf_out;
    logic        busy, mem_err;

    int tests_run = 0;
    int fails     = 0;
    logic [31:0] exp_load = 32'h0;

    rv32_ex_mem_queue #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .code_in        (code_in),
        .pc_in          (pc_in),
        .alu_result_in  (alu_result_in),
        .rf_rs2_in      (rf_rs2_in),
        .sel_rd1_in     (sel_rd1_in),
        .rf_in          (rf_in),
        .data_ctrl_in   (data_ctrl_in),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .code_out       (code_out),
        .pc_out         (pc_out),
        .alu_result_out (alu_result_out),
        .load_data_out  (load_data_out),
        .sel_rd1_out    (sel_rd1_out),
        .rf_out         (rf_out),
        .busy           (busy),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Load result from the architectural rule: byte/half at the address, then extend
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        v = word >> (8 * int'(addr[1:0]));
        case (f3)
            F3_B:    return {{24{v[7]}}, v[7:0]};
            F3_BU:   return {24'h0, v[7:0]};
            F3_H:    return {{16{v[15]}}, v[15:0]};
            F3_HU:   return {16'h0, v[15:0]};
            default: return word;
        endcase
    endfunction

    // One instruction through the stage; starts and ends at a negedge with the DUT idle
    task automatic step_txn(input logic [31:0] code, input logic [31:0] pc, input logic [31:0] alu,
                            input logic [31:0] rs2, input logic [4:0] rd, input logic [2:0] rf,
                            input logic [1:0] dc, input int ack_dly, input logic [31:0] rdata);
        logic [2:0]  f3;
        bit          is_mem, mis, tmo, acked, exp_we, exp_err;
        int          sz, off;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_be;
        logic [2:0]  exp_rf;

        f3       = code[14:12];
        is_mem   = dc[1];
        off      = int'(alu[1:0]);
        sz       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis      = is_mem && ((off % sz) != 0);
        exp_addr = alu & 32'hFFFF_FFFC;
        exp_we   = ~dc[0];
        if (sz == 1) begin
            exp_wdata = {4{rs2[7:0]}};
            exp_be    = 4'(1 << off);
        end else if (sz == 2) begin
            exp_wdata = {2{rs2[15:0]}};
            exp_be    = 4'(3 << off);
        end else begin
            exp_wdata = rs2;
            exp_be    = 4'hF;
        end

        code_in = code; pc_in = pc; alu_result_in = alu; rf_rs2_in = rs2;
        sel_rd1_in = rd; rf_in = rf; data_ctrl_in = dc; dmem_ack = 1'b0;
        @(posedge clk); @(negedge clk);

        tmo   = 1'b0;
        acked = 1'b0;
        if (is_mem && !mis) begin
            for (int i = 1; i <= ACK_TIMEOUT && !acked; i++) begin
                check("wait_busy",  32'(busy), 32'd1);
                check("wait_req",   32'(dmem_req), 32'd1);
                check("wait_we",    32'(dmem_we), 32'(exp_we));
                check("wait_addr",  dmem_addr, exp_addr);
                check("wait_be",    32'(dmem_be), 32'(exp_be));
                check("wait_wdata", dmem_wdata, exp_wdata);
                check("wait_rfwen", 32'(rf_out[0]), 32'd0);
                check("wait_err",   32'(mem_err), 32'd0);
                acked      = (i == ack_dly);
                dmem_ack   = acked;
                dmem_rdata = acked ? rdata : $urandom();
                @(posedge clk); @(negedge clk);
            end
            dmem_ack = 1'b0;
            tmo      = !acked;
            if (acked && dc[0]) exp_load = ref_load(f3, alu, rdata);
        end

        exp_rf  = rf;
        exp_err = is_mem && (mis || tmo);
        if (exp_err) exp_rf[0] = 1'b0;
        check("out_busy", 32'(busy), 32'd0);
        check("out_req",  32'(dmem_req), 32'd0);
        check("out_err",  32'(mem_err), 32'(exp_err));
        check("out_code", code_out, code);
        check("out_pc",   pc_out, pc);
        check("out_alu",  alu_result_out, alu);
        check("out_rd",   32'(sel_rd1_out), 32'(rd));
        check("out_rf",   32'(rf_out), 32'(exp_rf));
        check("out_load", load_data_out, exp_load);
        $display("[TB] txn dc=%b f3=%b addr=%08h ack=%0d mis=%0d tmo=%0d load=%08h",
                 dc, f3, alu, ack_dly, mis, tmo, load_data_out);

        // A late ack after an abort must not revive the access or touch load data
        if (tmo) begin
            dmem_ack = 1'b1; dmem_rdata = $urandom();
            data_ctrl_in = DATA_CTRL_NOP; rf_in = RF_NOP;
            @(posedge clk); @(negedge clk);
            dmem_ack = 1'b0;
            check("late_busy", 32'(busy), 32'd0);
            check("late_req",  32'(dmem_req), 32'd0);
            check("late_err",  32'(mem_err), 32'd0);
            check("late_load", load_data_out, exp_load);
            check("late_rf",   32'(rf_out), 32'd0);
        end
    endtask

    function automatic logic [31:0] mk_code(input logic [2:0] f3);
        logic [31:0] c;
        c = $urandom();
        c[14:12] = f3;
        return c;
    endfunction

    initial begin
        logic [2:0]  ld_f3 [5];
        logic [2:0]  f3;
        logic [31:0] a;
        logic [1:0]  dc;
        int          kind, dly;

        ld_f3[0] = F3_B; ld_f3[1] = F3_H; ld_f3[2] = F3_W; ld_f3[3] = F3_BU; ld_f3[4] = F3_HU;

        rst = 1'b1;
        code_in = '0; pc_in = '0; alu_result_in = '0; rf_rs2_in = '0;
        sel_rd1_in = '0; rf_in = '0; data_ctrl_in = DATA_CTRL_NOP;
        dmem_ack = 1'b0; dmem_rdata = '0;
        @(negedge clk); @(negedge clk);
        check("rst_alu",  alu_result_out, 32'h0);
        check("rst_load", load_data_out, 32'h0);
        check("rst_rf",   32'(rf_out), 32'h0);
        check("rst_req",  32'(dmem_req), 32'h0);
        check("rst_be",   32'(dmem_be), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err",  32'(mem_err), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        step_txn(32'h0000_0033, 32'h100, 32'h1234, 32'h0, 5'd5, 3'b001, 2'b00, 0, 32'h0);
        step_txn(mk_code(F3_B),  32'h104, 32'h1003, 32'h0, 5'd6, 3'b011, 2'b11, 1, 32'h80FF_0000);
        check("lb_value", load_data_out, 32'hFFFF_FF80);
        step_txn(mk_code(F3_BU), 32'h108, 32'h1003, 32'h0, 5'd7, 3'b011, 2'b11, 1, 32'h80FF_0000);
        check("lbu_value", load_data_out, 32'h0000_0080);
        step_txn(mk_code(F3_H),  32'h10C, 32'h2002, 32'hABCD_1234, 5'd0, 3'b000, 2'b10, 3, 32'h0);
        step_txn(mk_code(F3_W),  32'h110, 32'h3001, 32'h0, 5'd8, 3'b011, 2'b11, 1, 32'h0);
        step_txn(mk_code(F3_W),  32'h114, 32'h3000, 32'h0, 5'd9, 3'b011, 2'b11, 0, 32'h0);
        step_txn(mk_code(F3_W),  32'h118, 32'h3004, 32'h0, 5'd10, 3'b011, 2'b11, ACK_TIMEOUT, 32'hCAFE_F00D);
        check("ack_at_limit", load_data_out, 32'hCAFE_F00D);

        // Randomized transactions
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            dly  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, ACK_TIMEOUT);
            a    = $urandom();
            if (kind == 1) f3 = ld_f3[$urandom_range(0, 4)];
            else           f3 = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if (kind == 0)      dc = $urandom_range(0, 1) ? 2'b00 : 2'b01;
            else if (kind == 1) dc = 2'b11;
            else                dc = 2'b10;
            step_txn(mk_code(f3), $urandom(), a, $urandom(), 5'($urandom()), 3'($urandom()),
                     dc, dly, $urandom());
        end

        // Reset in the second ACCESS cycle
        code_in = mk_code(F3_W); alu_result_in = 32'h4000; data_ctrl_in = 2'b11; rf_in = 3'b011;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_req",  32'(dmem_req), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rf",   32'(rf_out), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        exp_load = 32'h0;
        step_txn(32'h0000_0013, 32'h200, 32'h55AA, 32'h0, 5'd3, 3'b001, 2'b00, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
